lfsr_stream: RTL

//  Parametrised LFSR generator: Fibonacci or Galois form, 1..WIDTH bits per

---
 rtl/lfsr_stream_if.sv | 23 ++
 rtl/lfsr_stream.sv | 117 +++++++++++
 2 files changed

// File: rtl/lfsr_stream_if.sv
// Output stream bundle of the LFSR generator: valid/ready handshake
// carrying STEP freshly shifted-out bits per transfer.
interface lfsr_stream_if #(
    parameter int STEP = 1
);
    logic            out_valid;
    logic            out_ready;
    logic [STEP-1:0] out_data;

    // Producer side (the LFSR)
    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    // Consumer side
    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/lfsr_stream.sv
// Parametrised LFSR stream source (Fibonacci or Galois form) producing
// STEP bits per accepted transfer, with runtime seeding, entropy mixing
// on every step and automatic recovery from the all-zero lockup state.
module lfsr_stream #(
    parameter int               WIDTH      = 16,
    parameter int               STEP       = 1,
    parameter int               GALOIS     = 0,
    parameter logic [WIDTH-1:0] INIT_VALUE = 16'hACE1,
    parameter logic [WIDTH-1:0] FEEDBACK   = 16'h002D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STEP-1:0]   random,
    input  logic              seed_valid,
    input  logic [WIDTH-1:0]  seed,
    lfsr_stream_if.master     out_if,
    output logic [WIDTH-1:0]  state,
    output logic              seed_rej,
    output logic [7:0]        lockups
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } fsm_t;

    // Galois taps never include the MSB: that position receives the
    // shifted-out bit itself.
    localparam logic [WIDTH-1:0] GAL_MASK = {1'b0, FEEDBACK[WIDTH-2:0]};

    fsm_t             fsm_reg, fsm_next;
    logic [WIDTH-1:0] state_reg, state_next;
    logic [7:0]       lockups_reg, lockups_next;
    logic             seed_rej_reg, seed_rej_next;

    logic [WIDTH-1:0] step_state;
    logic [STEP-1:0]  step_bits;
    logic             out_valid_w;
    logic             transfer;

    // Chain STEP single steps; each step's output bit is the LSB it shifts out
    always_comb begin
        step_state = state_reg;
        step_bits  = '0;
        for (int i = 0; i < STEP; i++) begin
            step_bits[i] = step_state[0];
            if (GALOIS != 0) begin
                step_state = {step_state[0] ^ random[i], step_state[WIDTH-1:1]}
                           ^ ({WIDTH{step_state[0]}} & GAL_MASK);
            end else begin
                step_state = {random[i] ^ (^(step_state & FEEDBACK)),
                              step_state[WIDTH-1:1]};
            end
        end
    end

    // A zero state is never presented as data; it is being recovered
    assign out_valid_w = (fsm_reg == ST_RUN) && (state_reg != '0);
    assign transfer    = out_valid_w && out_if.out_ready;

    // Next-state logic: INIT loads the start value, RUN applies seed > lockup > transfer
    always_comb begin
        fsm_next      = fsm_reg;
        state_next    = state_reg;
        lockups_next  = lockups_reg;
        seed_rej_next = 1'b0;
        case (fsm_reg)
            ST_INIT: begin
                state_next = INIT_VALUE;
                fsm_next   = ST_RUN;
            end
            ST_RUN: begin
                if (seed_valid && (seed != '0)) begin
                    // A coincident transfer is consumed; its data was the old state
                    state_next = seed;
                end else begin
                    if (seed_valid) begin
                        seed_rej_next = 1'b1;
                    end
                    if (state_reg == '0) begin
                        state_next = INIT_VALUE;
                        if (lockups_reg != 8'hFF) begin
                            lockups_next = lockups_reg + 8'd1;
                        end
                    end else if (transfer) begin
                        state_next = step_state;
                    end
                end
            end
            default: begin
                fsm_next = ST_INIT;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg      <= ST_INIT;
            state_reg    <= '0;
            lockups_reg  <= 8'h00;
            seed_rej_reg <= 1'b0;
        end else begin
            fsm_reg      <= fsm_next;
            state_reg    <= state_next;
            lockups_reg  <= lockups_next;
            seed_rej_reg <= seed_rej_next;
        end
    end

    assign out_if.out_valid = out_valid_w;
    assign out_if.out_data  = step_bits;
    assign state            = state_reg;
    assign seed_rej         = seed_rej_reg;
    assign lockups          = lockups_reg;

endmodule
